// File: rtl/arbiter_vc_pkg.sv
// Shared definitions for the virtual-channel arbiter and its source/destination FIFOs:
// the state encoding, the default word geometry and the raw-state decoder.
package arbiter_vc_pkg;

  // Default word geometry shared by the FIFOs and the arbiter.
  localparam int DATA_SIZE_DEF = 6;
  localparam int DEST_BIT_DEF  = 4;

  // Arbiter FSM encoding. Encoding 3 is unused and is treated as IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  // Map the raw 2-bit state register onto a legal state.
  function automatic state_t decode_state(input logic [1:0] raw);
    case (raw)
      2'd1:    return ACTIVE;
      2'd2:    return STALL;
      default: return IDLE;
    endcase
  endfunction

endpackage : arbiter_vc_pkg

// File: rtl/arbiter_vc_dest_demux.sv
// Destination demultiplexer: steers one forwarded word to d0 or d1 by its
// destination bit. The data output that is not being written keeps its last value.
module dest_demux
  import arbiter_vc_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DEST_BIT  = DEST_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [DATA_SIZE-1:0] word,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1
);

  logic [DATA_SIZE-1:0] hold_d0;
  logic [DATA_SIZE-1:0] hold_d1;

  // Decode the destination and show the new word in the same cycle as its push.
  always_comb begin
    push_d0 = valid && !word[DEST_BIT];
    push_d1 = valid &&  word[DEST_BIT];
    data_d0 = push_d0 ? word : hold_d0;
    data_d1 = push_d1 ? word : hold_d1;
  end

  // Remember the last word written to each destination.
  // NOTE: sequential state is updated only with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_d0 <= '0;
      hold_d1 <= '0;
    end else begin
      if (push_d0) hold_d0 <= word;
      if (push_d1) hold_d1 <= word;
    end
  end

endmodule : dest_demux

// File: rtl/arbiter_vc.sv
// Two-source, two-destination arbiter. It pops VC0 with strict priority over VC1
// while no destination is pausing. It forwards each popped word one cycle later to
// the destination selected by its destination bit, and counts words per destination.
module arbiter_vc
  import arbiter_vc_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DEST_BIT  = DEST_BIT_DEF,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty_vc0,
  input  logic                 fifo_empty_vc1,
  input  logic [DATA_SIZE-1:0] data_vc0,
  input  logic [DATA_SIZE-1:0] data_vc1,
  input  logic                 pause_d0,
  input  logic                 pause_d1,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] count_d0,
  output logic [CNT_WIDTH-1:0] count_d1,
  output logic                 idle
);

  logic [1:0]           state_q;         // raw state register
  state_t               cur_state;       // decoded state (3 -> IDLE)
  logic                 pause_any;
  logic                 src_ready;       // at least one source holds a word
  logic                 pop_any;
  logic                 inflight_q;      // a word was popped last cycle
  logic                 inflight_src_q;  // 0: it came from VC0, 1: from VC1
  logic                 fwd_valid;
  logic [DATA_SIZE-1:0] fwd_word;

  // Pop decision from the registered state, source selection and status flags.
  // NOTE: every signal gets a value on every path in always_comb, so no latch can appear.
  always_comb begin
    cur_state = decode_state(state_q);
    pause_any = pause_d0 | pause_d1;
    src_ready = !fifo_empty_vc0 || !fifo_empty_vc1;
    pop_vc0   = 1'b0;
    pop_vc1   = 1'b0;
    if (!reset && (cur_state == ACTIVE) && !pause_any) begin
      pop_vc0 = !fifo_empty_vc0;
      pop_vc1 =  fifo_empty_vc0 && !fifo_empty_vc1;
    end
    pop_any   = pop_vc0 | pop_vc1;
    fwd_valid = inflight_q && !reset;
    fwd_word  = inflight_src_q ? data_vc1 : data_vc0;
    idle      = (cur_state == IDLE) && !inflight_q;
  end

  // FSM plus the in-flight tracking of the word popped this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      inflight_q     <= 1'b0;
      inflight_src_q <= 1'b0;
    end else begin
      inflight_q     <= pop_any;
      inflight_src_q <= pop_vc1;
      case (cur_state)
        IDLE: begin
          if (src_ready) state_q <= pause_any ? STALL : ACTIVE;
          else           state_q <= IDLE;
        end
        ACTIVE: begin
          if (!src_ready && !inflight_q) state_q <= IDLE;
          else if (pause_any)            state_q <= STALL;
        end
        STALL: begin
          if (!src_ready && !inflight_q)   state_q <= IDLE;
          else if (!pause_any && src_ready) state_q <= ACTIVE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-destination forwarded-word counters. They wrap naturally at 2**CNT_WIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_d0 <= '0;
      count_d1 <= '0;
    end else begin
      if (push_d0) count_d0 <= count_d0 + CNT_WIDTH'(1);
      if (push_d1) count_d1 <= count_d1 + CNT_WIDTH'(1);
    end
  end

  dest_demux #(
    .DATA_SIZE (DATA_SIZE),
    .DEST_BIT  (DEST_BIT)
  ) u_dest_demux (
    .clk     (clk),
    .reset   (reset),
    .valid   (fwd_valid),
    .word    (fwd_word),
    .push_d0 (push_d0),
    .push_d1 (push_d1),
    .data_d0 (data_d0),
    .data_d1 (data_d1)
  );

  assign state = state_q;

endmodule : arbiter_vc

// File: tb/tb_arbiter_vc.sv
// Self-checking bench for arbiter_vc: behavioural source FIFOs, a reference model of
// the arbiter, and a scoreboard of popped words that is checked at each push.
module tb_arbiter_vc;
  import arbiter_vc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty_vc0, fifo_empty_vc1;
  logic [5:0] data_vc0, data_vc1;
  logic       pause_d0, pause_d1;
  logic       pop_vc0, pop_vc1, push_d0, push_d1;
  logic [5:0] data_d0, data_d1;
  logic [1:0] state;
  logic [7:0] count_d0, count_d1;
  logic       idle;

  arbiter_vc dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty_vc0 (fifo_empty_vc0),
    .fifo_empty_vc1 (fifo_empty_vc1),
    .data_vc0       (data_vc0),
    .data_vc1       (data_vc1),
    .pause_d0       (pause_d0),
    .pause_d1       (pause_d1),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .push_d0        (push_d0),
    .push_d1        (push_d1),
    .data_d0        (data_d0),
    .data_d1        (data_d1),
    .state          (state),
    .count_d0       (count_d0),
    .count_d1       (count_d1),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         pushes0;
  logic [5:0] q0[$], q1[$];     // source FIFO contents
  logic [5:0] sb[$];            // scoreboard: popped words awaiting their push
  int         pop_src_log[$], pop_cyc_log[$], push_dst_log[$], push_cyc_log[$];
  state_t     m_state;
  logic       m_infl;
  logic [7:0] m_cnt0, m_cnt1;
  logic [5:0] m_data0, m_data1;
  logic       last_pop0, last_pop1, last_push0, last_push1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load0(input logic [5:0] w);
    q0.push_back(w);
    fifo_empty_vc0 = 1'b0;
  endtask

  task automatic load1(input logic [5:0] w);
    q1.push_back(w);
    fifo_empty_vc1 = 1'b0;
  endtask

  // One clock: check DUT outputs mid-cycle against the model, then advance the
  // model and the source FIFOs across the rising edge.
  task automatic cycle();
    logic       pa, src, ep0, ep1, epush;
    logic [5:0] w;
    state_t     nstate;
    w = '0;
    @(negedge clk);
    pa  = pause_d0 | pause_d1;
    src = !fifo_empty_vc0 || !fifo_empty_vc1;
    ep0 = !reset && (m_state == ACTIVE) && !pa && !fifo_empty_vc0;
    ep1 = !reset && (m_state == ACTIVE) && !pa && fifo_empty_vc0 && !fifo_empty_vc1;
    epush = !reset && m_infl;
    if (epush) begin
      w = sb.pop_front();
      if (w[4]) m_data1 = w;
      else      m_data0 = w;
    end
    check("pop_vc0", pop_vc0, ep0);
    check("pop_vc1", pop_vc1, ep1);
    check("state", state, m_state);
    check("idle", idle, (m_state == IDLE) && !m_infl);
    check("count_d0", count_d0, m_cnt0);
    check("count_d1", count_d1, m_cnt1);
    check("push_d0", push_d0, epush && !w[4]);
    check("push_d1", push_d1, epush && w[4]);
    check("data_d0", data_d0, m_data0);
    check("data_d1", data_d1, m_data1);
    last_pop0 = pop_vc0;  last_pop1 = pop_vc1;
    last_push0 = push_d0; last_push1 = push_d1;
    if (pop_vc0) begin pop_src_log.push_back(0); pop_cyc_log.push_back(cyc); end
    if (pop_vc1) begin pop_src_log.push_back(1); pop_cyc_log.push_back(cyc); end
    if (push_d0) begin push_dst_log.push_back(0); push_cyc_log.push_back(cyc); pushes0++; end
    if (push_d1) begin push_dst_log.push_back(1); push_cyc_log.push_back(cyc); end
    nstate = m_state;
    case (m_state)
      IDLE:   if (src) nstate = pa ? STALL : ACTIVE;
      ACTIVE: if (!src && !m_infl) nstate = IDLE; else if (pa) nstate = STALL;
      STALL:  if (!src && !m_infl) nstate = IDLE; else if (!pa && src) nstate = ACTIVE;
      default: nstate = IDLE;
    endcase
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_state = IDLE; m_infl = 1'b0;
      m_cnt0 = '0; m_cnt1 = '0; m_data0 = '0; m_data1 = '0;
      sb.delete();
    end else begin
      if (epush && !w[4]) m_cnt0 = m_cnt0 + 8'd1;
      if (epush &&  w[4]) m_cnt1 = m_cnt1 + 8'd1;
      m_infl  = ep0 | ep1;
      m_state = nstate;
    end
    #1;
    if (ep0) begin data_vc0 = q0.pop_front(); sb.push_back(data_vc0); end
    if (ep1) begin data_vc1 = q1.pop_front(); sb.push_back(data_vc1); end
    fifo_empty_vc0 = (q0.size() == 0);
    fifo_empty_vc1 = (q1.size() == 0);
  endtask

  initial begin
    int exp_src[3];
    exp_src = '{0, 0, 1};
    reset = 1'b1; fifo_empty_vc0 = 1'b1; fifo_empty_vc1 = 1'b1;
    data_vc0 = '0; data_vc1 = '0; pause_d0 = 1'b0; pause_d1 = 1'b0;
    m_state = IDLE; m_infl = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
    m_data0 = '0; m_data1 = '0; pushes0 = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    check("reset_state", state, IDLE);
    check("reset_idle", idle, 1'b1);
    reset = 1'b0;
    cycle();

    // Single word 0x15 from VC0 goes to d1 one cycle after its pop.
    load0(6'h15);
    last_push1 = 1'b0;
    pop_cyc_log.delete(); push_cyc_log.delete();
    for (int i = 0; i < 10 && !last_push1; i++) cycle();
    check("t1_push_seen", last_push1, 1'b1);
    check("t1_data_d1", data_d1, 6'h15);
    check("t1_count_d1", count_d1, 8'd1);
    if (pop_cyc_log.size() == 1 && push_cyc_log.size() == 1)
      check("t1_latency", push_cyc_log[0] - pop_cyc_log[0], 1);
    else
      check("t1_log_sizes", pop_cyc_log.size() + push_cyc_log.size(), 2);
    repeat (4) cycle();

    // Both sources loaded: VC0 has strict priority, one word per cycle.
    pop_src_log.delete(); pop_cyc_log.delete();
    push_dst_log.delete(); push_cyc_log.delete();
    load0(6'h01); load0(6'h02); load1(6'h13);
    repeat (10) cycle();
    check("t2_pop_count", pop_src_log.size(), 3);
    check("t2_push_count", push_dst_log.size(), 3);
    for (int i = 0; i < 3 && i < pop_src_log.size() && i < push_dst_log.size(); i++) begin
      check($sformatf("t2_pop_src%0d", i), pop_src_log[i], exp_src[i]);
      check($sformatf("t2_push_dst%0d", i), push_dst_log[i], exp_src[i]);
      check($sformatf("t2_push_lat%0d", i), push_cyc_log[i] - pop_cyc_log[i], 1);
      if (i > 0) check($sformatf("t2_b2b%0d", i), pop_cyc_log[i] - pop_cyc_log[i-1], 1);
    end

    // A pause rising right after a pop still lets that word through, then stalls.
    load0(6'h03); load0(6'h05);
    last_pop0 = 1'b0;
    for (int i = 0; i < 10 && !last_pop0; i++) cycle();
    check("t3_pop_seen", last_pop0, 1'b1);
    pause_d0 = 1'b1;
    cycle();
    check("t3_push_under_pause", last_push0, 1'b1);
    check("t3_data_d0", data_d0, 6'h03);
    check("t3_no_pop", last_pop0, 1'b0);
    check("t3_state_stall", state, STALL);
    repeat (3) cycle();
    pause_d0 = 1'b0;
    cycle();
    check("t3_release_no_pop", last_pop0, 1'b0);
    check("t3_state_active", state, ACTIVE);
    cycle();
    check("t3_pop_resumes", last_pop0, 1'b1);
    repeat (4) cycle();

    // Reset in the cycle after a pop discards the in-flight word.
    load0(6'h0A);
    last_pop0 = 1'b0;
    for (int i = 0; i < 10 && !last_pop0; i++) cycle();
    check("t5_pop_seen", last_pop0, 1'b1);
    reset = 1'b1;
    cycle();
    check("t5_no_push", last_push0, 1'b0);
    reset = 1'b0;
    repeat (3) cycle();
    check("t5_state_idle", state, IDLE);
    check("t5_idle", idle, 1'b1);
    check("t5_count_d0", count_d0, 8'd0);
    check("t5_count_d1", count_d1, 8'd0);

    // 256 words of 0x00 wrap count_d0 back to zero.
    pushes0 = 0;
    for (int i = 0; i < 256; i++) load0(6'h00);
    for (int i = 0; i < 400 && pushes0 < 256; i++) cycle();
    check("t4_pushes", pushes0, 256);
    check("t4_count_d0_wrap", count_d0, 8'd0);
    check("t4_count_d1", count_d1, 8'd0);
    repeat (3) cycle();

    // Mixed random traffic with toggling pauses.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 4) load0(6'($urandom_range(0, 63)));
      if ($urandom_range(0, 2) == 0 && q1.size() < 4) load1(6'($urandom_range(0, 63)));
      if ($urandom_range(0, 7) == 0) pause_d0 = !pause_d0;
      if ($urandom_range(0, 9) == 0) pause_d1 = !pause_d1;
      cycle();
    end
    pause_d0 = 1'b0; pause_d1 = 1'b0;
    repeat (30) cycle();
    check("t6_drained_idle", idle, 1'b1);
    check("t6_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_arbiter_vc

// File: doc/arbiter_vc.md
ARBITER_VC -- requirements
Module: arbiter_vc

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 6, meaning word width including destination bit.
REQ-002 SHALL have parameter DEST_BIT, default 4, meaning word bit selecting destination (0 -> d0, 1 -> d1).
REQ-003 SHALL have parameter CNT_WIDTH, default 8, meaning width of forwarded-word counters.
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports: fifo_empty_vc0, fifo_empty_vc1  in  1 each  source FIFO empty flags.
REQ-006 SHALL have ports: data_vc0, data_vc1  in  DATA_SIZE each  source FIFO read data, valid the cycle after a pop.
REQ-007 SHALL have ports: pause_d0, pause_d1  in  1 each  destination almost-full flags.
REQ-008 SHALL have ports: pop_vc0, pop_vc1  out  1 each  source pop strobes.
REQ-009 SHALL have ports: push_d0, push_d1  out  1 each; data_d0, data_d1  out  DATA_SIZE each  destination write strobe and data.
REQ-010 SHALL have ports: state  out  2  FSM state; count_d0, count_d1  out  CNT_WIDTH each  words forwarded per destination; idle  out  1  no traffic and nothing in flight.

Function
REQ-011 SHALL implement FSM states IDLE=0, ACTIVE=1, STALL=2; encoding 3 unused, decoded as IDLE.
REQ-012 SHALL transition IDLE->ACTIVE when either fifo_empty_vcX is 0 and both pauses are 0; IDLE->STALL when a source is non-empty and any pause is 1.
REQ-013 SHALL transition ACTIVE->STALL when pause_d0|pause_d1 is 1; STALL->ACTIVE when both pauses are 0 and a source is non-empty; ACTIVE/STALL->IDLE when both sources empty and no word in flight.
REQ-014 SHALL assert pop_vc0 combinationally in cycle N iff state is ACTIVE, fifo_empty_vc0=0, and pause_d0=pause_d1=0.
REQ-015 SHALL assert pop_vc1 iff the pop_vc0 conditions hold with fifo_empty_vc0=1 and fifo_empty_vc1=0 (strict VC0 priority); pop_vc0 and pop_vc1 never both 1.
REQ-016 SHALL register in-flight valid and source select at end of a pop cycle N; in cycle N+1 select data_vc0 or data_vc1 by that source.
REQ-017 SHALL in cycle N+1 assert exactly one of push_d0/push_d1 per bit DEST_BIT of the selected word, drive the word unmodified on the matching data_dX, and hold the other data_dX at its previous value.
REQ-018 SHALL complete an in-flight push even if a pause rises in cycle N+1 (destination thresholds leave one slot of slack).
REQ-019 SHALL allow a new pop in cycle N+1 while pushing the word popped in cycle N (one word per cycle throughput).
REQ-020 SHALL increment count_dX by 1 on each push_dX cycle, wrapping from 2**CNT_WIDTH-1 to 0.
REQ-021 SHALL drive idle=1 iff state is IDLE and no word in flight.
REQ-022 SHALL never pop while state is IDLE or STALL, including the cycle of a state change (pop decision uses current registered state).

Reset
REQ-023 SHALL, while reset=1 at a clk edge, set state=IDLE, in-flight valid=0, count_d0=count_d1=0, data_d0=data_d1=0.
REQ-024 SHALL hold pop_vc0, pop_vc1, push_d0, push_d1 at 0 in any cycle where reset=1, regardless of inputs.
REQ-025 SHALL discard an in-flight word when reset asserts mid-operation; no push of it after reset deasserts.

Structure
REQ-026 SHALL place state encodings IDLE/ACTIVE/STALL and DATA_SIZE/DEST_BIT defaults in a shared package include used by the FIFOs and arbiter.
REQ-027 SHALL contain one sub-module, dest_demux, mapping (valid, word) to push_d0/push_d1/data_d0/data_d1; all other logic local.

Verification
REQ-028 SHALL cover: vc0 holds 0x15 (bit4=1), vc1 empty, no pause -> pop_vc0 cycle N, push_d1 with data_d1=0x15 cycle N+1, count_d1=1.
REQ-029 SHALL cover: both sources non-empty, vc0 words 0x01,0x02 and vc1 word 0x13 -> pops vc0,vc0,vc1 back-to-back; pushes d0,d0,d1 one cycle later each.
REQ-030 SHALL cover: pause_d0 rises the cycle after a pop of 0x03 -> push_d0 of 0x03 still occurs, no further pop, state=STALL; pause falls -> ACTIVE and pops resume next cycle.
REQ-031 SHALL cover: 256 words of 0x00 forwarded -> count_d0 wraps to 0, count_d1=0.
REQ-032 SHALL cover: reset=1 in the cycle after a pop -> no push, counts=0, state=IDLE, idle=1 once sources empty.
